data_proc_frame_seq: RTL and testbench

Frame-level sequencer for the data_proc pixel accelerator. On a start pulse it:
- writes the mode and the 3x3 kernel into data_proc through its register port;
- streams frame_len bytes from a source byte buffer into the pixel port, honouring ready_in;
- writes every processed pixel to a destination byte buffer;
- signals done.

It sits between the CPU-facing register block and data_proc, so firmware no longer feeds pixels one bus access at a time.

---
 rtl/data_proc_frame_seq_if.sv | 27 ++
 rtl/data_proc_frame_seq.sv | 128 ++++++++++++
 tb/tb_data_proc_frame_seq.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_proc_frame_seq_if.sv
// data_proc_frame_seq_if: source/destination byte buffer ports and data_proc pixel/register ports.
interface data_proc_frame_seq_if #(parameter int ADDR_W = 12);
    logic              src_rd;
    logic [ADDR_W-1:0] src_addr;
    logic [7:0]        src_rdata;
    logic              dst_we;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        dst_wdata;
    logic [7:0]        dp_pixel_in;
    logic              dp_valid_in;
    logic              dp_ready_in;
    logic [7:0]        dp_pixel_out;
    logic              dp_valid_out;
    logic              dp_write_reg;
    logic [7:0]        dp_address;
    logic [71:0]       dp_data_in;
    modport master (
        output src_rd, src_addr, dst_we, dst_addr, dst_wdata,
        output dp_pixel_in, dp_valid_in, dp_write_reg, dp_address, dp_data_in,
        input  src_rdata, dp_ready_in, dp_pixel_out, dp_valid_out
    );
    modport slave (
        input  src_rd, src_addr, dst_we, dst_addr, dst_wdata,
        input  dp_pixel_in, dp_valid_in, dp_write_reg, dp_address, dp_data_in,
        output src_rdata, dp_ready_in, dp_pixel_out, dp_valid_out
    );
endinterface

// File: rtl/data_proc_frame_seq.sv
// data_proc_frame_seq: configures data_proc, streams a frame through it and stores the results.
// Optional cycle_count output enabled by DATA_PROC_FRAME_SEQ_CYCLE_CNT_EN.
module data_proc_frame_seq #(
    parameter int ADDR_W    = 12,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_len,
    input  logic [1:0]        mode,
    input  logic [71:0]       kernel,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
`ifdef DATA_PROC_FRAME_SEQ_CYCLE_CNT_EN
    output logic [31:0]       cycle_count,
`endif
    data_proc_frame_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, CFG_MODE, CFG_KERN, STREAM, DRAIN, FIN} state_t;
    state_t                state;
    logic [ADDR_W-1:0]     len, issue_cnt, in_cnt, out_cnt;
    logic [71:0]           kern_r;
    logic                  inflight, hold_vld;
    logic [7:0]            hold_data;
    logic [TIMEOUT_W-1:0]  wd;
    logic                  accept, fetch, capture, pix_vld;
    always_comb begin
        pix_vld          = state == STREAM && hold_vld;
        accept           = pix_vld && bus.dp_ready_in;
        fetch            = state == STREAM && issue_cnt < len && !inflight && (!hold_vld || accept);
        capture          = (state == STREAM || state == DRAIN) && bus.dp_valid_out && out_cnt < len;
        bus.src_rd       = fetch;
        bus.src_addr     = fetch ? issue_cnt : '0;
        bus.dp_valid_in  = pix_vld;
        bus.dp_pixel_in  = pix_vld ? hold_data : '0;
        bus.dst_we       = capture;
        bus.dst_addr     = capture ? out_cnt : '0;
        bus.dst_wdata    = capture ? bus.dp_pixel_out : '0;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            len              <= '0;
            issue_cnt        <= '0;
            in_cnt           <= '0;
            out_cnt          <= '0;
            kern_r           <= '0;
            inflight         <= 1'b0;
            hold_vld         <= 1'b0;
            hold_data        <= '0;
            wd               <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            timeout_err      <= 1'b0;
            bus.dp_write_reg <= 1'b0;
            bus.dp_address   <= '0;
            bus.dp_data_in   <= '0;
        end else begin
            done             <= 1'b0;
            bus.dp_write_reg <= 1'b0;
            bus.dp_address   <= '0;
            bus.dp_data_in   <= '0;
            inflight         <= fetch;
            if (fetch) issue_cnt <= issue_cnt + 1'b1;
            if (accept) in_cnt <= in_cnt + 1'b1;
            if (capture) out_cnt <= out_cnt + 1'b1;
            // a returning read always lands in an empty or just-drained holding register
            if (inflight) begin
                hold_data <= bus.src_rdata;
                hold_vld  <= 1'b1;
            end else if (accept) begin
                hold_vld  <= 1'b0;
            end
            case (state)
                IDLE: if (start) begin
                    len              <= frame_len;
                    kern_r           <= kernel;
                    timeout_err      <= 1'b0;
                    busy             <= 1'b1;
                    issue_cnt        <= '0;
                    in_cnt           <= '0;
                    out_cnt          <= '0;
                    bus.dp_write_reg <= 1'b1;
                    bus.dp_data_in   <= {70'b0, mode};
                    state            <= CFG_MODE;
                end
                CFG_MODE: begin
                    bus.dp_write_reg <= 1'b1;
                    bus.dp_address   <= 8'h04;
                    bus.dp_data_in   <= kern_r;
                    state            <= CFG_KERN;
                end
                CFG_KERN: begin
                    done  <= len == '0;
                    state <= len == '0 ? FIN : STREAM;
                end
                STREAM: if (in_cnt == len) begin
                    wd    <= '0;
                    state <= DRAIN;
                end
                DRAIN: if (out_cnt == len) begin
                    done  <= 1'b1;
                    state <= FIN;
                end else if (&wd) begin
                    timeout_err <= 1'b1;
                    done        <= 1'b1;
                    state       <= FIN;
                end else begin
                    wd <= bus.dp_valid_out ? '0 : wd + 1'b1;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef DATA_PROC_FRAME_SEQ_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cycle_count <= '0;
        else if (state == IDLE && start) cycle_count <= '0;
        else if (busy && !(&cycle_count)) cycle_count <= cycle_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_data_proc_frame_seq.sv
// tb_data_proc_frame_seq: directed scenarios against buffer and data_proc behavioural models.
module tb_data_proc_frame_seq;
    localparam int AW = 12;
    localparam logic [71:0] KERN = 72'h090807060504030201;
    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] frame_len = '0;
    logic [1:0]    mode = 2'd0;
    logic [71:0]   kernel = '0;
    logic          busy, done, timeout_err;
    logic          ready = 1'b1;
`ifdef DATA_PROC_FRAME_SEQ_CYCLE_CNT_EN
    logic [31:0]   cycle_count;
`endif
    data_proc_frame_seq_if #(.ADDR_W(AW)) bus ();
    data_proc_frame_seq #(.ADDR_W(AW), .TIMEOUT_W(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .frame_len(frame_len),
        .mode(mode), .kernel(kernel), .busy(busy), .done(done), .timeout_err(timeout_err),
`ifdef DATA_PROC_FRAME_SEQ_CYCLE_CNT_EN
        .cycle_count(cycle_count),
`endif
        .bus(bus)
    );
    assign bus.dp_ready_in = ready;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, acc_n = 0, rd_n = 0, we_n = 0, done_n = 0, cfg_n = 0, drop_idx = 0;
    int done_cyc = 0, last_we_cyc = 0;
    bit early_valid = 1'b0;
    logic [1:0]  m_mode = 2'd0;
    logic [7:0]  src_mem [0:15];
    logic [7:0]  dst_mem [0:15];
    bit          dst_wr  [0:15];
    logic [7:0]  acc_log [0:15];
    logic [7:0]  cfg_addr [0:3];
    logic [71:0] cfg_data [0:3];
    int          cfg_cyc  [0:3];

    // source buffer, destination buffer and a one-cycle data_proc model
    always @(posedge clk) begin
        cyc++;
        bus.src_rdata <= bus.src_rd ? src_mem[bus.src_addr[3:0]] : 8'h00;
        if (bus.src_rd) rd_n++;
        if (bus.dst_we) begin
            dst_mem[bus.dst_addr[3:0]] = bus.dst_wdata;
            dst_wr[bus.dst_addr[3:0]]  = 1'b1;
            we_n++;
            last_we_cyc = cyc;
        end
        if (bus.dp_write_reg) begin
            if (cfg_n < 4) begin
                cfg_addr[cfg_n] = bus.dp_address;
                cfg_data[cfg_n] = bus.dp_data_in;
                cfg_cyc[cfg_n]  = cyc;
            end
            cfg_n++;
            if (bus.dp_address == 8'h00) m_mode = bus.dp_data_in[1:0];
        end
        if (bus.dp_valid_in && cfg_n < 2) early_valid = 1'b1;
        bus.dp_valid_out <= 1'b0;
        if (bus.dp_valid_in && ready) begin
            if (acc_n < 16) acc_log[acc_n] = bus.dp_pixel_in;
            acc_n++;
            if (acc_n != drop_idx) begin
                bus.dp_valid_out <= 1'b1;
                bus.dp_pixel_out <= m_mode == 2'd1 ? ~bus.dp_pixel_in : bus.dp_pixel_in;
            end
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task clr;
        acc_n = 0; rd_n = 0; we_n = 0; cfg_n = 0; drop_idx = 0; early_valid = 1'b0;
        for (int i = 0; i < 16; i++) dst_wr[i] = 1'b0;
    endtask

    task kick(input logic [AW-1:0] l, input logic [1:0] m, input logic [71:0] k);
        frame_len = l; mode = m; kernel = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task wait_done(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task test_reset;
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, timeout_err} !== 3'b000) begin
            failures++; $display("FAIL reset_status got %b want 000", {busy, done, timeout_err});
        end
        checks++;
        if ({bus.src_rd, bus.src_addr, bus.dst_we, bus.dst_addr, bus.dst_wdata, bus.dp_valid_in,
             bus.dp_pixel_in, bus.dp_write_reg, bus.dp_address, bus.dp_data_in} !== '0) begin
            failures++; $display("FAIL reset_bus got nonzero want 0");
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task test_basic;
        bit seen;
        int d0;
        logic [7:0] e [4];
        e = '{8'hEF, 8'hDF, 8'hCF, 8'hBF};
        clr(); d0 = done_n;
        src_mem[0] = 8'h10; src_mem[1] = 8'h20; src_mem[2] = 8'h30; src_mem[3] = 8'h40;
        kick(4, 2'd1, '0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_done(seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL basic_done got 0 want 1"); end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL basic_after got %b want 00", {busy, done}); end
        checks++;
        if (done_n - d0 != 1) begin failures++; $display("FAIL basic_done_cnt got %0d want 1", done_n - d0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dst_mem[i] !== e[i]) begin failures++; $display("FAIL basic_dst%0d got %h want %h", i, dst_mem[i], e[i]); end
        end
        checks++;
        if (we_n != 4 || timeout_err !== 1'b0) begin
            failures++; $display("FAIL basic_we_to got %0d/%b want 4/0", we_n, timeout_err);
        end
    endtask

    task test_config;
        bit seen;
        clr();
        src_mem[0] = 8'h55; src_mem[1] = 8'h66;
        kick(2, 2'd2, KERN);
        wait_done(seen);
        @(negedge clk);
        checks++;
        if (!seen || cfg_n != 2) begin failures++; $display("FAIL cfg_count got %0d want 2", cfg_n); end
        checks++;
        if (cfg_addr[0] !== 8'h00 || cfg_data[0] !== 72'd2) begin
            failures++; $display("FAIL cfg_mode got %h/%h want 00/2", cfg_addr[0], cfg_data[0]);
        end
        checks++;
        if (cfg_addr[1] !== 8'h04 || cfg_data[1] !== KERN) begin
            failures++; $display("FAIL cfg_kern got %h/%h want 04/%h", cfg_addr[1], cfg_data[1], KERN);
        end
        checks++;
        if (cfg_cyc[1] != cfg_cyc[0] + 1 || early_valid) begin
            failures++; $display("FAIL cfg_order got gap %0d early %b want 1/0", cfg_cyc[1] - cfg_cyc[0], early_valid);
        end
        checks++;
        if (dst_mem[0] !== 8'h55 || dst_mem[1] !== 8'h66) begin
            failures++; $display("FAIL cfg_dst got %h %h want 55 66", dst_mem[0], dst_mem[1]);
        end
    endtask

    task test_backpressure;
        bit seen;
        clr();
        for (int i = 0; i < 8; i++) src_mem[i] = 8'hA0 + 8'(i);
        kick(8, 2'd1, '0);
        for (int n = 0; n < 100 && acc_n < 2; n++) @(negedge clk);
        checks++;
        if (acc_n != 2) begin failures++; $display("FAIL bp_reach got %0d want 2", acc_n); end
        ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if (bus.dp_valid_in !== 1'b1 || bus.dp_pixel_in !== 8'hA2) begin
                failures++; $display("FAIL bp_stall%0d got %b/%h want 1/a2", s, bus.dp_valid_in, bus.dp_pixel_in);
            end
        end
        checks++;
        if (acc_n != 2) begin failures++; $display("FAIL bp_hold got %0d want 2", acc_n); end
        ready = 1'b1;
        wait_done(seen);
        @(negedge clk);
        checks++;
        if (!seen || acc_n != 8) begin failures++; $display("FAIL bp_acc got %0d want 8", acc_n); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (acc_log[i] !== 8'hA0 + 8'(i) || dst_mem[i] !== ~(8'hA0 + 8'(i))) begin
                failures++; $display("FAIL bp_px%0d got %h/%h want %h/%h", i, acc_log[i], dst_mem[i], 8'hA0 + 8'(i), ~(8'hA0 + 8'(i)));
            end
        end
    endtask

    task test_zero_len;
        bit seen;
        clr();
        kick(0, 2'd0, KERN);
        wait_done(seen);
        @(negedge clk);
        checks++;
        if (!seen || cfg_n != 2) begin failures++; $display("FAIL zero_cfg got %0d want 2", cfg_n); end
        checks++;
        if (done_cyc != cfg_cyc[1] + 1) begin
            failures++; $display("FAIL zero_latency got %0d want 1", done_cyc - cfg_cyc[1]);
        end
        checks++;
        if (rd_n != 0 || we_n != 0) begin failures++; $display("FAIL zero_io got rd %0d we %0d want 0 0", rd_n, we_n); end
    endtask

    task test_timeout;
        bit seen;
        clr(); drop_idx = 3;
        src_mem[0] = 8'h01; src_mem[1] = 8'h02; src_mem[2] = 8'h03;
        kick(3, 2'd1, '0);
        wait_done(seen);
        @(negedge clk);
        checks++;
        if (!seen || timeout_err !== 1'b1) begin failures++; $display("FAIL to_flag got %b want 1", timeout_err); end
        checks++;
        if (dst_wr[2] || dst_mem[0] !== 8'hFE || dst_mem[1] !== 8'hFD) begin
            failures++; $display("FAIL to_dst got wr2 %b %h %h want 0 fe fd", dst_wr[2], dst_mem[0], dst_mem[1]);
        end
        checks++;
        if (done_cyc - last_we_cyc != 19) begin
            failures++; $display("FAIL to_delay got %0d want 19", done_cyc - last_we_cyc);
        end
        clr();
        kick(1, 2'd1, '0);
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear got %b want 0", timeout_err); end
        wait_done(seen);
        @(negedge clk);
        checks++;
        if (!seen || timeout_err !== 1'b0 || dst_mem[0] !== 8'hFE) begin
            failures++; $display("FAIL to_next got %b/%h want 0/fe", timeout_err, dst_mem[0]);
        end
    endtask

    task test_abort_restart;
        bit seen;
        int d0;
        clr();
        for (int i = 0; i < 8; i++) src_mem[i] = 8'h80 + 8'(i);
        kick(8, 2'd1, '0);
        for (int n = 0; n < 100 && acc_n < 2; n++) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, timeout_err, bus.src_rd, bus.dp_valid_in, bus.dst_we, bus.dp_write_reg} !== 7'b0) begin
            failures++; $display("FAIL abort_out got %b want 0", {busy, done, timeout_err, bus.src_rd, bus.dp_valid_in, bus.dst_we, bus.dp_write_reg});
        end
        d0 = done_n;
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (done_n != d0) begin failures++; $display("FAIL abort_done got %0d want 0", done_n - d0); end
        clr();
        src_mem[0] = 8'h33; src_mem[1] = 8'h44;
        kick(2, 2'd1, '0);
        @(negedge clk);
        kick(5, 2'd0, '0);
        wait_done(seen);
        repeat (20) @(negedge clk);
        checks++;
        if (!seen || done_n != d0 + 1 || busy !== 1'b0) begin
            failures++; $display("FAIL restart_done got %0d/%b want 1/0", done_n - d0, busy);
        end
        checks++;
        if (we_n != 2 || rd_n != 2 || dst_mem[0] !== 8'hCC || dst_mem[1] !== 8'hBB) begin
            failures++; $display("FAIL restart_dst got we %0d rd %0d %h %h want 2 2 cc bb", we_n, rd_n, dst_mem[0], dst_mem[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_config();
        test_backpressure();
        test_zero_len();
        test_timeout();
        test_abort_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
